reg_bank_ctrl: RTL

- Write controller for a small bank of D flip-flop registers shared by two requesters.
- Arbitrates write access round-robin with a combinational req/gnt handshake.
- Runs a sequenced clear that zeroes one entry per cycle; writes are blocked while it runs.
- Provides a combinational read port. Sits between datapath masters and the flop bank, which it owns.

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/reg_bank_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the two-requester register bank controller.
package reg_bank_pkg;

    localparam int NUM_REQ   = 2;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advanced on a taken grant.
module rr_arbiter2
    import reg_bank_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               upd_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // last_q=1 means requester 1 won most recently, so requester 0 is favoured next
    logic last_q, last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (upd_i) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Write controller for a small flop bank: round-robin write arbitration, sequenced clear, combinational read.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    input  logic             seq_clr,
    output logic             clr_busy,
    output logic             clr_done,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   bank_q [DEPTH];

    logic               wr_open;
    logic [1:0]         arb_req, arb_gnt;
    logic               upd;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [WIDTH-1:0]   wr_data;

    // A pending clear request wins over any write in the same cycle
    assign wr_open = (state_q != ST_CLEAR) && !seq_clr;
    assign arb_req = {req1, req0} & {2{wr_open}};

    rr_arbiter2 u_arb (
        .clk_i (clk),
        .rst_ni(clr_n),
        .req_i (arb_req),
        .upd_i (upd),
        .gnt_o (arb_gnt)
    );

    assign gnt0 = arb_gnt[0] & clr_n;
    assign gnt1 = arb_gnt[1] & clr_n;
    assign upd  = gnt0 | gnt1;

    // Out-of-range addresses still consume the grant but never touch the bank
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (gnt0) begin
            wr_en   = {1'b0, addr0} < DEPTH_C;
            wr_idx  = addr0[IDX_W-1:0];
            wr_data = wdata0;
        end else if (gnt1) begin
            wr_en   = {1'b0, addr1} < DEPTH_C;
            wr_idx  = addr1[IDX_W-1:0];
            wr_data = wdata1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (seq_clr) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                clr_done = 1'b1;
                state_d  = seq_clr ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else if (clr_busy) begin
            bank_q[idx_q] <= '0;
        end else if (wr_en) begin
            bank_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = ({1'b0, rd_addr} < DEPTH_C) ? bank_q[rd_addr[IDX_W-1:0]] : '0;

endmodule
